// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register file widths, zero register and arbiter state encoding
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 64;
    localparam int ZERO_REG = 31;

    typedef enum logic [0:0] {
        NORMAL  = 1'b0,
        STARVED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/starve_counter.sv
// rtl/starve_counter.sv - saturating MC refusal counter and NORMAL/STARVED state machine
module starve_counter
    import regfile_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic mc_valid,
    input  logic refused,
    input  logic granted,
    output logic starved
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    arb_state_t state;
    arb_state_t state_next;
    logic [3:0] wait_cnt;
    logic [3:0] cnt_next;

    always_comb begin
        cnt_next = wait_cnt;
        if (granted || !mc_valid) begin
            cnt_next = 4'd0;
        end else if (refused && (wait_cnt < MAX_CNT)) begin
            cnt_next = wait_cnt + 4'd1;
        end
    end

    // Entering STARVED on the refusal that saturates the counter makes the
    // forced grant land in the very next cycle.
    always_comb begin
        state_next = state;
        case (state)
            NORMAL: begin
                if (refused && (cnt_next == MAX_CNT)) begin
                    state_next = STARVED;
                end
            end
            STARVED: begin
                if (granted || !mc_valid) begin
                    state_next = NORMAL;
                end
            end
            default: state_next = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= NORMAL;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= cnt_next;
        end
    end

    assign starved = (state == STARVED);

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register file write port between WB and MC
module regfile_write_arbiter #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int MAX_WAIT = 4,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mc_valid,
    output logic              mc_ready,
    input  logic [ADDR_W-1:0] mc_addr,
    input  logic [DATA_W-1:0] mc_data,
    output logic              rf_wr_ena,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              rf_wr_src,
    output logic              mc_starved
);

    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic              starved;
    logic              grant_mc;
    logic              grant_wb;
    logic              any_grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // MC wins on a matching address because it is the older instruction.
    always_comb begin
        grant_mc  = reset_n && mc_valid && (!wb_valid || starved || (mc_addr == wb_addr));
        grant_wb  = reset_n && wb_valid && !grant_mc;
        any_grant = grant_mc || grant_wb;
        sel_addr  = grant_mc ? mc_addr : wb_addr;
        sel_data  = grant_mc ? mc_data : wb_data;
    end

    assign wb_ready   = grant_wb;
    assign mc_ready   = grant_mc;
    assign mc_starved = starved;

    starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .mc_valid (mc_valid),
        .refused  (mc_valid && !grant_mc),
        .granted  (grant_mc),
        .starved  (starved)
    );

    // Zero-register writes complete the handshake but never assert the enable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rf_wr_ena  <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            rf_wr_src  <= 1'b0;
        end else begin
            rf_wr_ena <= any_grant && (sel_addr != ZERO_ADDR);
            if (any_grant) begin
                rf_wr_addr <= sel_addr;
                rf_wr_data <= sel_data;
                rf_wr_src  <= grant_mc;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - randomized bench for regfile_write_arbiter against a reference model
module tb_regfile_write_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_addr;
    logic [63:0] mc_data;
    logic        rf_wr_ena;
    logic [4:0]  rf_wr_addr;
    logic [63:0] rf_wr_data;
    logic        rf_wr_src;
    logic        mc_starved;

    regfile_write_arbiter #(
        .DATA_W   (64),
        .ADDR_W   (5),
        .MAX_WAIT (MAX_WAIT),
        .ZERO_REG (31)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .mc_valid   (mc_valid),
        .mc_ready   (mc_ready),
        .mc_addr    (mc_addr),
        .mc_data    (mc_data),
        .rf_wr_ena  (rf_wr_ena),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .rf_wr_src  (rf_wr_src),
        .mc_starved (mc_starved)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model: count of consecutive MC refusals plus the last accepted write.
    int          m_refused;
    logic        m_ena;
    logic [4:0]  m_addr;
    logic [63:0] m_data;
    logic        m_src;
    logic        m_zeroed;
    logic        g_wb;
    logic        g_mc;

    logic        s_wb_ready;
    logic        s_mc_ready;
    logic        s_starved;
    logic        s_ena;
    logic [4:0]  s_addr;
    logic [63:0] s_data;
    logic        s_src;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        logic starved_exp;
        @(negedge clk);
        starved_exp = (m_refused >= MAX_WAIT);
        g_mc = reset_n && mc_valid && (!wb_valid || starved_exp || (mc_addr == wb_addr));
        g_wb = reset_n && wb_valid && !g_mc;
        s_wb_ready = wb_ready;
        s_mc_ready = mc_ready;
        s_starved  = mc_starved;
        s_ena      = rf_wr_ena;
        s_addr     = rf_wr_addr;
        s_data     = rf_wr_data;
        s_src      = rf_wr_src;
        check_eq("wb_ready", wb_ready, g_wb);
        check_eq("mc_ready", mc_ready, g_mc);
        check_eq("mc_starved", mc_starved, starved_exp);
        check_eq("rf_wr_ena", rf_wr_ena, m_ena);
        if (m_ena || m_zeroed) begin
            check_eq("rf_wr_addr", rf_wr_addr, m_addr);
            check_eq("rf_wr_data", rf_wr_data, m_data);
            check_eq("rf_wr_src", rf_wr_src, m_src);
        end
        @(posedge clk);
        if (!reset_n) begin
            m_refused = 0;
            m_ena     = 1'b0;
            m_addr    = '0;
            m_data    = '0;
            m_src     = 1'b0;
            m_zeroed  = 1'b1;
        end else begin
            if (g_mc || g_wb) begin
                m_addr   = g_mc ? mc_addr : wb_addr;
                m_data   = g_mc ? mc_data : wb_data;
                m_src    = g_mc;
                m_ena    = (m_addr != 5'd31);
                m_zeroed = 1'b0;
            end else begin
                m_ena = 1'b0;
            end
            if (mc_valid && !g_mc) m_refused = (m_refused < MAX_WAIT) ? m_refused + 1 : MAX_WAIT;
            else m_refused = 0;
        end
        #1;
    endtask

    task automatic drive(input logic rst, input logic wv, input logic [4:0] wa, input logic [63:0] wd,
                         input logic mv, input logic [4:0] ma, input logic [63:0] md);
        reset_n  = rst;
        wb_valid = wv;
        wb_addr  = wa;
        wb_data  = wd;
        mc_valid = mv;
        mc_addr  = ma;
        mc_data  = md;
        step();
    endtask

    initial begin
        logic wb_pend;
        logic mc_pend;
        reset_n  = 1'b0;
        wb_valid = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        mc_valid = 1'b0;
        mc_addr  = '0;
        mc_data  = '0;
        @(posedge clk);
        #1;
        m_refused = 0;
        m_ena     = 1'b0;
        m_addr    = '0;
        m_data    = '0;
        m_src     = 1'b0;
        m_zeroed  = 1'b1;

        // Reset held with a pending WB write
        drive(1'b0, 1'b1, 5'd5, 64'h55, 1'b0, 5'd0, 64'h0);
        check_eq("rst_wb_ready", s_wb_ready, 1'b0);
        drive(1'b0, 1'b1, 5'd5, 64'h55, 1'b0, 5'd0, 64'h0);
        check_eq("rst_ena", s_ena, 1'b0);
        check_eq("rst_addr", s_addr, 5'd0);
        drive(1'b1, 1'b1, 5'd5, 64'h55, 1'b0, 5'd0, 64'h0);
        check_eq("post_rst_grant", s_wb_ready, 1'b1);
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        check_eq("post_rst_ena", s_ena, 1'b1);
        check_eq("post_rst_addr", s_addr, 5'd5);

        // Single MC requester
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 64'hDEAD);
        check_eq("mc_single_ready", s_mc_ready, 1'b1);
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        check_eq("mc_single_data", s_data, 64'hDEAD);
        check_eq("mc_single_src", s_src, 1'b1);

        // Priority then forced grant after MAX_WAIT refusals
        for (int i = 0; i < MAX_WAIT; i++) begin
            drive(1'b1, 1'b1, 5'd3, 64'h30 + 64'(i), 1'b1, 5'd9, 64'h99);
            check_eq("prio_wb_grant", s_wb_ready, 1'b1);
        end
        drive(1'b1, 1'b1, 5'd3, 64'h77, 1'b1, 5'd9, 64'h99);
        check_eq("starve_flag", s_starved, 1'b1);
        check_eq("starve_mc_ready", s_mc_ready, 1'b1);
        check_eq("starve_wb_ready", s_wb_ready, 1'b0);
        drive(1'b1, 1'b1, 5'd3, 64'h77, 1'b0, 5'd0, 64'h0);
        check_eq("starve_addr", s_addr, 5'd9);
        check_eq("starve_exit", s_starved, 1'b0);
        check_eq("starve_wb_back", s_wb_ready, 1'b1);

        // Same-address ordering: MC first, then WB
        drive(1'b1, 1'b1, 5'd12, 64'h1, 1'b1, 5'd12, 64'h2);
        check_eq("same_mc_first", s_mc_ready, 1'b1);
        drive(1'b1, 1'b1, 5'd12, 64'h1, 1'b0, 5'd0, 64'h0);
        check_eq("same_wb_second", s_wb_ready, 1'b1);
        check_eq("same_data0", s_data, 64'h2);
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        check_eq("same_data1", s_data, 64'h1);

        // Zero-register suppression
        drive(1'b1, 1'b1, 5'd31, 64'hBAD, 1'b0, 5'd0, 64'h0);
        check_eq("zero_wb_ready", s_wb_ready, 1'b1);
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        check_eq("zero_ena", s_ena, 1'b0);

        // Reset right after a grant discards the write
        drive(1'b1, 1'b1, 5'd4, 64'h44, 1'b0, 5'd0, 64'h0);
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd6, 64'h66);
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        check_eq("midrst_ena", s_ena, 1'b0);
        check_eq("midrst_starved", s_starved, 1'b0);

        // Randomized traffic honouring the hold-until-accepted rule
        wb_pend = 1'b0;
        mc_pend = 1'b0;
        wb_valid = 1'b0;
        mc_valid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!mc_pend && ($urandom_range(0, 1) == 0)) begin
                mc_pend = 1'b1;
                mc_addr = 5'($urandom_range(0, 31));
                mc_data = {$urandom, $urandom};
            end
            if (!wb_pend && ($urandom_range(0, 3) != 0)) begin
                wb_pend = 1'b1;
                case ($urandom_range(0, 5))
                    0:       wb_addr = 5'd31;
                    1, 2:    wb_addr = mc_addr;
                    default: wb_addr = 5'($urandom_range(0, 31));
                endcase
                wb_data = {$urandom, $urandom};
            end
            wb_valid = wb_pend;
            mc_valid = mc_pend;
            reset_n  = ($urandom_range(0, 63) != 0);
            step();
            if (g_wb) wb_pend = 1'b0;
            if (g_mc) mc_pend = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
